exec_cc_stage: RTL and testbench
================================

EXEC_CC_STAGE -- requirements
Module: exec_cc_stage

Interface
REQ-001 Parameter: WIDTH, default 64, datapath width of the ALU result.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream ALU result valid.
REQ-005 in_ready  output  1  stage can accept an input this cycle.
REQ-006 alu_result  input  WIDTH  ALU output word.
REQ-007 zf_in, sf_in, of_in  input  1 each  ALU zero/sign/overflow flags (zf_in driven by the ALU zero-flag outputs, e.g. the AND zero flag).
REQ-008 set_cc  input  1  this instruction updates the condition codes.
REQ-009 icode  input  4  instruction code; ifun  input  4  function code.
REQ-010 flush  input  1  synchronous kill of the held entry.
REQ-011 out_valid  output  1  held entry valid.
REQ-012 out_ready  input  1  downstream accepts the held entry.
REQ-013 out_result  output  WIDTH  registered alu_result.
REQ-014 out_icode  output  4  registered icode.
REQ-015 out_cnd  output  1  registered condition outcome.
REQ-016 cc  output  3  architectural condition codes {ZF,SF,OF}.

Function
REQ-017 Single-entry pipeline register; in_ready = !out_valid | out_ready (combinational).
REQ-018 Accept = in_valid & in_ready & !flush; on accept, out_result/out_icode/out_cnd load on the next edge and out_valid=1.
REQ-019 Drain = out_valid & out_ready & no accept in the same cycle -> out_valid=0 next edge; accept and drain together -> new entry replaces old, out_valid stays 1.
REQ-020 Held entry (out_valid & !out_ready) stays bit-stable; in_ready=0.
REQ-021 Condition from ifun using the cc value before this instruction's update: 0 always=1; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=!ZF; 5 ge=!(SF^OF); 6 g=!(SF^OF)&!ZF; 7-15 =0.
REQ-022 out_cnd loads the condition only when icode is 4'h2 (cmov) or 4'h7 (jXX); all other icodes load 0.
REQ-023 cc loads {zf_in,sf_in,of_in} on the edge following an accept with set_cc=1 and icode=4'h6; otherwise cc holds.
REQ-024 set_cc=1 with icode other than 4'h6 is ignored (cc holds).
REQ-025 Back-to-back accepts: an instruction accepted in cycle N+1 evaluates its condition against cc as updated by the instruction accepted in cycle N.
REQ-026 Flush: out_valid=0 next edge; no accept and no cc update that cycle; flush wins over any simultaneous accept or drain; out_result/out_icode/out_cnd hold their values.
REQ-027 No combinational path from alu_result or the flags to any output.

Reset
REQ-028 While rst_n=0 (asserted independently of clk): out_valid=0, out_result=0, out_icode=0, out_cnd=0, cc=3'b100.
REQ-029 The first accept is possible on the first rising edge after rst_n deasserts; reset mid-transfer discards the held entry.

Verification
REQ-030 Reset then accept icode=6, set_cc=1, alu_result=0, zf_in=1 -> next cycle out_valid=1, out_result=0, cc=3'b100.
REQ-031 OPq with sf_in=1, of_in=0, zf_in=0, then jXX ifun=2 next cycle -> jXX out_cnd=1; same sequence with ifun=6 -> out_cnd=0.
REQ-032 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs unchanged; input presented meanwhile is accepted only after out_ready=1.
REQ-033 flush=1 with in_valid=1 and set_cc=1 -> out_valid=0 next edge, cc unchanged.
REQ-034 rst_n pulled low mid-cycle while out_valid=1 -> out_valid=0 and cc=3'b100 immediately, without waiting for a clock edge.
REQ-035 icode=2, ifun=9 -> out_cnd=0; icode=3, ifun=0 -> out_cnd=0; icode=7, ifun=0 -> out_cnd=1.

Source files
------------

// File: rtl/exec_cc_stage.sv
`default_nettype none
// ============================================================================
// Module   : exec_cc_stage
// Purpose  : Execute-stage output register with Y86 condition codes and
//            cmov/jXX condition evaluation.
// Revision : 1.0
// ============================================================================
module exec_cc_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             zf_in,
  input  logic             sf_in,
  input  logic             of_in,
  input  logic             set_cc,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_icode,
  output logic             out_cnd,
  output logic [2:0]       cc
);

  localparam logic [3:0] C_ICODE_CMOV = 4'h2;
  localparam logic [3:0] C_ICODE_OPQ  = 4'h6;
  localparam logic [3:0] C_ICODE_JXX  = 4'h7;
  localparam logic [2:0] C_CC_RESET   = 3'b100;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_icode;
  logic             r_cnd;
  logic [2:0]       r_cc;

  logic w_zf;
  logic w_sf;
  logic w_of;
  logic w_cond;
  logic w_cnd_next;
  logic w_accept;
  logic w_cc_load;

  assign w_zf = r_cc[2];
  assign w_sf = r_cc[1];
  assign w_of = r_cc[0];

  // Condition is evaluated against the committed cc; an OPq accepted in the
  // previous cycle has already written r_cc by the time the next one looks.
  always_comb begin
    w_cond = 1'b0;
    case (ifun)
      4'h0:    w_cond = 1'b1;
      4'h1:    w_cond = (w_sf ^ w_of) | w_zf;
      4'h2:    w_cond = w_sf ^ w_of;
      4'h3:    w_cond = w_zf;
      4'h4:    w_cond = ~w_zf;
      4'h5:    w_cond = ~(w_sf ^ w_of);
      4'h6:    w_cond = ~(w_sf ^ w_of) & ~w_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_cnd_next = ((icode == C_ICODE_CMOV) || (icode == C_ICODE_JXX)) ? w_cond : 1'b0;
  assign in_ready   = ~r_valid | out_ready;
  assign w_accept   = in_valid & in_ready & ~flush;
  assign w_cc_load  = w_accept & set_cc & (icode == C_ICODE_OPQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_icode  <= 4'h0;
      r_cnd    <= 1'b0;
      r_cc     <= C_CC_RESET;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid  <= 1'b1;
        r_result <= alu_result;
        r_icode  <= icode;
        r_cnd    <= w_cnd_next;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_cc_load) begin
        r_cc <= {zf_in, sf_in, of_in};
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_icode  = r_icode;
  assign out_cnd    = r_cnd;
  assign cc         = r_cc;

endmodule
`default_nettype wire

// File: tb/tb_exec_cc_stage.sv
`default_nettype none
// Directed testbench for exec_cc_stage: handshake, condition codes, flush, async reset.
module tb_exec_cc_stage;

  localparam int WIDTH = 64;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zf_in;
  logic             sf_in;
  logic             of_in;
  logic             set_cc;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_icode;
  logic             out_cnd;
  logic [2:0]       cc;

  int n_tests = 0;
  int n_fail  = 0;

  exec_cc_stage #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_result (alu_result),
    .zf_in      (zf_in),
    .sf_in      (sf_in),
    .of_in      (of_in),
    .set_cc     (set_cc),
    .icode      (icode),
    .ifun       (ifun),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_icode  (out_icode),
    .out_cnd    (out_cnd),
    .cc         (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic sc, input logic [WIDTH-1:0] r, input logic [2:0] f);
    in_valid   = v;
    icode      = ic;
    ifun       = fn;
    set_cc     = sc;
    alu_result = r;
    {zf_in, sf_in, of_in} = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 3'b000);
    #12;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_tests++; if (out_result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", out_result); end
    n_tests++; if (out_icode !== 4'h0) begin n_fail++; $display("FAIL reset_icode: got %h want 0", out_icode); end
    n_tests++; if (out_cnd !== 1'b0) begin n_fail++; $display("FAIL reset_cnd: got %b want 0", out_cnd); end
    n_tests++; if (cc !== 3'b100) begin n_fail++; $display("FAIL reset_cc: got %b want 100", cc); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_opq_zero();
    drive(1'b1, 4'h6, 4'h0, 1'b1, '0, 3'b100);
    step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL opq_valid: got %b want 1", out_valid); end
    n_tests++; if (out_result !== '0) begin n_fail++; $display("FAIL opq_result: got %h want 0", out_result); end
    n_tests++; if (cc !== 3'b100) begin n_fail++; $display("FAIL opq_cc: got %b want 100", cc); end
    n_tests++; if (out_icode !== 4'h6) begin n_fail++; $display("FAIL opq_icode: got %h want 6", out_icode); end
    n_tests++; if (out_cnd !== 1'b0) begin n_fail++; $display("FAIL opq_cnd: got %b want 0", out_cnd); end
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 3'b000);
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    // OPq sets SF, next-cycle jl must see it
    drive(1'b1, 4'h6, 4'h0, 1'b1, 64'h5, 3'b010);
    step();
    n_tests++; if (cc !== 3'b010) begin n_fail++; $display("FAIL b2b_cc: got %b want 010", cc); end
    drive(1'b1, 4'h7, 4'h2, 1'b0, 64'h0, 3'b000);
    step();
    n_tests++; if (out_cnd !== 1'b1) begin n_fail++; $display("FAIL b2b_jl_cnd: got %b want 1", out_cnd); end
    n_tests++; if (out_icode !== 4'h7) begin n_fail++; $display("FAIL b2b_jl_icode: got %h want 7", out_icode); end
    drive(1'b1, 4'h6, 4'h0, 1'b1, 64'h0, 3'b100);
    step();
    drive(1'b1, 4'h6, 4'h0, 1'b1, 64'h5, 3'b010);
    step();
    drive(1'b1, 4'h7, 4'h6, 1'b0, 64'h0, 3'b000);
    step();
    n_tests++; if (out_cnd !== 1'b0) begin n_fail++; $display("FAIL b2b_jg_cnd: got %b want 0", out_cnd); end
    drive(1'b1, 4'h7, 4'h5, 1'b0, 64'h0, 3'b000);
    step();
    n_tests++; if (out_cnd !== 1'b0) begin n_fail++; $display("FAIL b2b_jge_cnd: got %b want 0", out_cnd); end
    // set_cc on a non-OPq instruction must be ignored
    drive(1'b1, 4'h2, 4'h1, 1'b1, 64'h0, 3'b001);
    step();
    n_tests++; if (cc !== 3'b010) begin n_fail++; $display("FAIL ignore_setcc_cc: got %b want 010", cc); end
    n_tests++; if (out_cnd !== 1'b1) begin n_fail++; $display("FAIL cmovle_cnd: got %b want 1", out_cnd); end
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 3'b000);
    step();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 4'h7, 4'h0, 1'b0, 64'hAAAA, 3'b000);
    step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_load_valid: got %b want 1", out_valid); end
    out_ready = 1'b0;
    drive(1'b1, 4'h6, 4'h0, 1'b1, 64'h5555, 3'b001);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      step();
      n_tests++; if (out_result !== 64'hAAAA || out_icode !== 4'h7 || out_valid !== 1'b1 || out_cnd !== 1'b1)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got %h/%h/%b/%b want aaaa/7/1/1", i, out_result, out_icode, out_valid, out_cnd); end
      n_tests++; if (cc !== 3'b010) begin n_fail++; $display("FAIL bp_cc[%0d]: got %b want 010", i, cc); end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    step();
    n_tests++; if (out_result !== 64'h5555 || out_icode !== 4'h6) begin n_fail++; $display("FAIL bp_accept: got %h/%h want 5555/6", out_result, out_icode); end
    n_tests++; if (cc !== 3'b001) begin n_fail++; $display("FAIL bp_accept_cc: got %b want 001", cc); end
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 3'b000);
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 4'h7, 4'h0, 1'b0, 64'h1234, 3'b000);
    step();
    flush = 1'b1;
    drive(1'b1, 4'h6, 4'h0, 1'b1, 64'h9999, 3'b100);
    step();
    flush = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 3'b000);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_tests++; if (cc !== 3'b001) begin n_fail++; $display("FAIL flush_cc: got %b want 001", cc); end
    n_tests++; if (out_result !== 64'h1234 || out_icode !== 4'h7) begin n_fail++; $display("FAIL flush_hold: got %h/%h want 1234/7", out_result, out_icode); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'h6, 4'h0, 1'b1, 64'hDEAD_BEEF_0123_4567, 3'b011);
    step();
    out_ready = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 3'b000);
    step();
    n_tests++; if (out_valid !== 1'b1 || cc !== 3'b011 || out_result !== 64'hDEAD_BEEF_0123_4567)
      begin n_fail++; $display("FAIL pre_areset: got %b/%b/%h want 1/011/deadbeef01234567", out_valid, cc, out_result); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    n_tests++; if (cc !== 3'b100) begin n_fail++; $display("FAIL areset_cc: got %b want 100", cc); end
    n_tests++; if (out_result !== '0) begin n_fail++; $display("FAIL areset_result: got %h want 0", out_result); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'h7, 4'h0, 1'b0, 64'h42, 3'b000);
    step();
    n_tests++; if (out_valid !== 1'b1 || out_icode !== 4'h7 || out_cnd !== 1'b1)
      begin n_fail++; $display("FAIL first_accept: got %b/%h/%b want 1/7/1", out_valid, out_icode, out_cnd); end
  endtask

  task automatic test_icode_gate();
    logic [3:0] ic_tab [5] = '{4'h2, 4'h3, 4'h7, 4'h2, 4'h7};
    logic [3:0] fn_tab [5] = '{4'h9, 4'h0, 4'h0, 4'h3, 4'h4};
    logic       ex_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    // cc is 100 here: ZF set
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ic_tab[i], fn_tab[i], 1'b0, 64'(i), 3'b000);
      step();
      n_tests++; if (out_cnd !== ex_tab[i])
        begin n_fail++; $display("FAIL gate[%0d] icode=%h ifun=%h: got %b want %b", i, ic_tab[i], fn_tab[i], out_cnd, ex_tab[i]); end
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 3'b000);
    step();
  endtask

  initial begin
    test_reset();
    test_opq_zero();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_icode_gate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
